// File: rtl/joy_db15_responder_if.sv
// DB15 joystick link signals between a host (reader) and the device-side responder.
// The host drives the shift clock, the load strobe and the button state to export.
// The responder returns serial data plus status.
interface joy_db15_responder_if #(
    parameter int BITS_PER_PLAYER = 12
);
    localparam int IDX_W = $clog2(2 * BITS_PER_PLAYER + 1);

    logic                       joy_clk;
    logic                       joy_load;
    logic [BITS_PER_PLAYER-1:0] joystick1;
    logic [BITS_PER_PLAYER-1:0] joystick2;
    logic                       joy_data;
    logic                       frame_done;
    logic                       host_active;
    logic [IDX_W-1:0]           bit_index;

    modport master (
        output joy_clk,
        output joy_load,
        output joystick1,
        output joystick2,
        input  joy_data,
        input  frame_done,
        input  host_active,
        input  bit_index
    );

    modport slave (
        input  joy_clk,
        input  joy_load,
        input  joystick1,
        input  joystick2,
        output joy_data,
        output frame_done,
        output host_active,
        output bit_index
    );
endinterface

// File: rtl/joy_db15_responder.sv
// Device-side DB15 joystick responder: emulates a 74HC165-style parallel-in
// serial-out chain. The host pulls joy_load low to capture both players' buttons
// and then clocks them out on joy_data, one bit per joy_clk rising edge.
// The bits go out active-low, player 1 first and bit 0 first.
module joy_db15_responder #(
    parameter int BITS_PER_PLAYER = 12,
    parameter int SYNC_STAGES     = 2,        // must be >= 2
    parameter int TIMEOUT_CYCLES  = 2400000   // must fit in 22 bits
) (
    input  logic                 clk,
    input  logic                 reset,
    joy_db15_responder_if.slave  joy
);
    localparam int TOTAL = 2 * BITS_PER_PLAYER;
    localparam int IDX_W = $clog2(TOTAL + 1);
    localparam logic [21:0] TIMEOUT_VAL = 22'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] load_sync_reg;
    logic                   clk_prev_reg;
    logic                   load_prev_reg;

    state_t                 state_reg;
    logic [TOTAL-1:0]       sr_reg;
    logic [IDX_W-1:0]       bit_index_reg;
    logic                   frame_done_reg;
    logic                   host_active_reg;
    logic [21:0]            wdog_reg;

    logic clk_s;
    logic load_s;
    logic clk_rise;
    logic load_fall;

    // Bring the asynchronous host strobes into the clk domain. Keep the previous
    // synced value so that edges can be detected on the clean copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_reg  <= '1;
            load_sync_reg <= '1;
            clk_prev_reg  <= 1'b1;
            load_prev_reg <= 1'b1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], joy.joy_clk};
            load_sync_reg <= {load_sync_reg[SYNC_STAGES-2:0], joy.joy_load};
            clk_prev_reg  <= clk_s;
            load_prev_reg <= load_s;
        end
    end

    assign clk_s     = clk_sync_reg[SYNC_STAGES-1];
    assign load_s    = load_sync_reg[SYNC_STAGES-1];
    assign clk_rise  = clk_s & ~clk_prev_reg;
    assign load_fall = ~load_s & load_prev_reg;

    // Frame FSM with watchdog.
    // A load fall always wins: it aborts any frame and restarts the watchdog.
    // The watchdog expiring parks the chain idle with all-ones data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            sr_reg          <= '1;
            bit_index_reg   <= IDX_W'(TOTAL);
            frame_done_reg  <= 1'b0;
            host_active_reg <= 1'b0;
            wdog_reg        <= '0;
        end else begin
            frame_done_reg <= 1'b0;
            if (load_fall) begin
                wdog_reg        <= '0;
                host_active_reg <= 1'b1;
                state_reg       <= ST_LOAD;
                sr_reg          <= ~{joy.joystick2, joy.joystick1};
                bit_index_reg   <= '0;
            end else begin
                if (wdog_reg != TIMEOUT_VAL) begin
                    wdog_reg <= wdog_reg + 22'd1;
                end
                if (wdog_reg == TIMEOUT_VAL - 22'd1) begin
                    host_active_reg <= 1'b0;
                    state_reg       <= ST_IDLE;
                    sr_reg          <= '1;
                    bit_index_reg   <= IDX_W'(TOTAL);
                end else begin
                    case (state_reg)
                        ST_LOAD: begin
                            // Transparent while the strobe is low; the last capture is held on release.
                            if (!load_s) begin
                                sr_reg        <= ~{joy.joystick2, joy.joystick1};
                                bit_index_reg <= '0;
                            end else begin
                                state_reg <= ST_SHIFT;
                            end
                        end
                        ST_SHIFT: begin
                            if (clk_rise && load_s) begin
                                sr_reg <= {1'b1, sr_reg[TOTAL-1:1]};
                                if (bit_index_reg == IDX_W'(TOTAL - 1)) begin
                                    bit_index_reg  <= IDX_W'(TOTAL);
                                    frame_done_reg <= 1'b1;
                                    state_reg      <= ST_DONE;
                                end else begin
                                    bit_index_reg <= bit_index_reg + IDX_W'(1);
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    // The register is all ones in IDLE and DONE, so bit 0 gives the idle-high line directly.
    assign joy.joy_data    = sr_reg[0];
    assign joy.frame_done  = frame_done_reg;
    assign joy.host_active = host_active_reg;
    assign joy.bit_index   = bit_index_reg;
endmodule

// File: tb/tb_joy_db15_responder.sv
// Self-checking bench for joy_db15_responder: table-driven full frames plus
// hand-written sequences for abort, simultaneous edges, reset and watchdog.
module tb_joy_db15_responder;
    logic clk = 1'b0;
    logic reset;

    joy_db15_responder_if #(.BITS_PER_PLAYER(12)) jif ();

    joy_db15_responder #(
        .BITS_PER_PLAYER(12),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .joy  (jif.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int fd_count = 0;

    // Count frame_done pulses just after the edge that produces them.
    always @(posedge clk) begin
        #1;
        if (jif.frame_done === 1'b1) fd_count++;
    end

    typedef struct {
        logic [11:0] j1;
        logic [11:0] j2;
        logic [23:0] frame;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // All stimulus tasks start and end on a negative clock edge.
    task automatic pulse_clk();
        jif.joy_clk = 1'b1;
        @(negedge clk);
        jif.joy_clk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_load(input logic [11:0] j1, input logic [11:0] j2);
        jif.joystick1 = j1;
        jif.joystick2 = j2;
        jif.joy_load  = 1'b0;
        repeat (3) @(negedge clk);
        jif.joy_load  = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic shift_out(input int n, input int start, output logic [23:0] bits, output int idx_bad);
        bits    = '1;
        idx_bad = 0;
        for (int k = 0; k < n; k++) begin
            bits[start + k] = jif.joy_data;
            if (jif.bit_index !== 5'(start + k)) idx_bad++;
            pulse_clk();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [23:0] bits;
        int          bad;
        int          fd0;
        int          cnt;

        vecs[0] = '{12'h001, 12'h000, 24'hFFFFFE};
        vecs[1] = '{12'hA5A, 12'h5A5, 24'hA5A5A5};
        vecs[2] = '{12'hFFF, 12'hFFF, 24'h000000};
        vecs[3] = '{12'h000, 12'h800, 24'h7FFFFF};
        vecs[4] = '{12'h010, 12'h010, 24'hFEFFEF};
        vecs[5] = '{12'h123, 12'h456, 24'hBA9EDC};

        reset         = 1'b1;
        jif.joy_clk   = 1'b0;
        jif.joy_load  = 1'b1;
        jif.joystick1 = '0;
        jif.joystick2 = '0;
        repeat (3) @(negedge clk);
        check("reset joy_data", 32'(jif.joy_data), 1);
        check("reset frame_done", 32'(jif.frame_done), 0);
        check("reset host_active", 32'(jif.host_active), 0);
        check("reset bit_index", 32'(jif.bit_index), 24);
        reset = 1'b0;
        @(negedge clk);

        // Full frames; joysticks are scrambled after the load to prove they are ignored.
        for (int v = 0; v < 6; v++) begin
            fd0 = fd_count;
            do_load(vecs[v].j1, vecs[v].j2);
            jif.joystick1 = ~vecs[v].j1;
            jif.joystick2 = ~vecs[v].j2;
            shift_out(24, 0, bits, bad);
            check($sformatf("vec%0d frame", v), 32'(bits), 32'(vecs[v].frame));
            check($sformatf("vec%0d bit_index seq", v), 32'(bad), 0);
            check($sformatf("vec%0d end bit_index", v), 32'(jif.bit_index), 24);
            check($sformatf("vec%0d end joy_data", v), 32'(jif.joy_data), 1);
            check($sformatf("vec%0d frame_done count", v), 32'(fd_count - fd0), 1);
        end

        // A 25th clock after a complete frame changes nothing.
        fd0 = fd_count;
        do_load(12'hA5A, 12'h5A5);
        shift_out(24, 0, bits, bad);
        pulse_clk();
        check("extra clk bit_index", 32'(jif.bit_index), 24);
        check("extra clk joy_data", 32'(jif.joy_data), 1);
        check("extra clk frame_done count", 32'(fd_count - fd0), 1);

        // Abort after 10 bits by reloading with new buttons.
        fd0 = fd_count;
        do_load(12'h001, 12'h000);
        shift_out(10, 0, bits, bad);
        check("abort partial bits", 32'(bits[9:0]), 32'h3FE);
        check("abort bit_index before reload", 32'(jif.bit_index), 10);
        jif.joystick1 = 12'hFFF;
        jif.joy_load  = 1'b0;
        repeat (3) @(negedge clk);
        check("abort reload bit_index", 32'(jif.bit_index), 0);
        check("abort reload joy_data", 32'(jif.joy_data), 0);
        check("abort no frame_done", 32'(fd_count - fd0), 0);
        jif.joy_load = 1'b1;
        repeat (3) @(negedge clk);
        shift_out(24, 0, bits, bad);
        check("abort new frame", 32'(bits), 32'hFFF000);
        check("abort frame_done count", 32'(fd_count - fd0), 1);

        // joy_clk rise and joy_load fall in the same cycle: load wins.
        do_load(12'hA5A, 12'h5A5);
        shift_out(5, 0, bits, bad);
        jif.joystick1 = 12'h3C3;
        jif.joystick2 = 12'h0F0;
        jif.joy_clk   = 1'b1;
        jif.joy_load  = 1'b0;
        @(negedge clk);
        jif.joy_clk = 1'b0;
        repeat (2) @(negedge clk);
        check("simul bit_index", 32'(jif.bit_index), 0);
        check("simul joy_data", 32'(jif.joy_data), 0);
        jif.joy_load = 1'b1;
        repeat (3) @(negedge clk);
        shift_out(24, 0, bits, bad);
        check("simul frame", 32'(bits), 32'hF0FC3C);
        check("simul bit_index seq", 32'(bad), 0);

        // Reset in the middle of a frame.
        do_load(12'hA5A, 12'h5A5);
        shift_out(4, 0, bits, bad);
        check("pre-reset joy_data", 32'(jif.joy_data), 0);
        reset = 1'b1;
        @(negedge clk);
        check("mid reset joy_data", 32'(jif.joy_data), 1);
        check("mid reset frame_done", 32'(jif.frame_done), 0);
        check("mid reset host_active", 32'(jif.host_active), 0);
        check("mid reset bit_index", 32'(jif.bit_index), 24);
        reset = 1'b0;
        @(negedge clk);

        // Watchdog: host_active stays up exactly TIMEOUT_CYCLES after the load fall.
        jif.joystick1 = 12'h001;
        jif.joystick2 = 12'h000;
        jif.joy_load  = 1'b0;
        cnt = 0;
        while (jif.host_active !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("watchdog host_active rise", 32'(jif.host_active), 1);
        jif.joy_load = 1'b1;
        cnt = 0;
        while (jif.host_active === 1'b1 && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        check("watchdog cycles", 32'(cnt), 100);
        check("watchdog joy_data", 32'(jif.joy_data), 1);
        check("watchdog bit_index", 32'(jif.bit_index), 24);
        jif.joy_load = 1'b0;
        repeat (3) @(negedge clk);
        check("watchdog reload host_active", 32'(jif.host_active), 1);
        check("watchdog reload bit_index", 32'(jif.bit_index), 0);
        jif.joy_load = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
